// File: rtl/dmem_responder.sv
// Multi-cycle data memory with programmable wait states and pipeline stall.
// Optional alignment check compiled in with `define DMEM_ALIGN_CHECK_EN (adds err_o).
module dmem_responder #(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        done_o,
  output logic        stall_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        err_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic            r_wr;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_mis;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_idle;
  logic            w_accept;
  logic            w_commit;
  logic            w_wr;
  logic            w_mis;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_wdata;
  logic            w_unused_addr;

  assign w_req    = MemRead_i | MemWrite_i;
  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle & w_req;
  assign w_commit = (w_next == DONE);

  // With zero wait states the commit happens on the accept edge, so take the
  // request straight from the inputs; otherwise use the latched copy.
  assign w_wr    = w_idle ? MemWrite_i       : r_wr;
  assign w_idx   = w_idle ? addr_i[AW+1:2]   : r_idx;
  assign w_wdata = w_idle ? data_i           : r_wdata;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis = w_idle ? (addr_i[1:0] != 2'b00) : r_mis;
`else
  assign w_mis = 1'b0;
`endif

  assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_next = (WAIT_CYCLES == 0) ? DONE : BUSY;
      BUSY:    if (r_cnt == 4'd1) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    done_o  = 1'b0;
    unique case (r_state)
      IDLE:    stall_o = w_req;
      BUSY:    stall_o = 1'b1;
      DONE:    done_o  = 1'b1;
      default: ;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign err_o = (r_state == DONE) & r_mis;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_mis   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= 4'(WAIT_CYCLES);
      r_wr    <= MemWrite_i;
      r_idx   <= addr_i[AW+1:2];
      r_wdata <= data_i;
      r_mis   <= w_mis;
    end else if (r_state == BUSY) begin
      r_cnt   <= r_cnt - 4'd1;
    end else begin
      r_cnt   <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else if (w_commit && !w_mis) begin
      if (w_wr) r_mem[w_idx] <= w_wdata;
      else      r_rdata      <= r_mem[w_idx];
    end
  end

  assign data_o = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: reset, table vectors, random ops
// against an array model, reset mid-access and a zero-wait-state instance.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned W     = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        done, stall, err;
  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [31:0] rdata0;
  logic        done0, stall0, err0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk_i(clk), .rst_n(rst_n), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(wdata), .data_o(rdata), .done_o(done),
    .stall_o(stall)
`ifdef DMEM_ALIGN_CHECK_EN
    , .err_o(err)
`endif
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_n(rst_n), .MemRead_i(rd0), .MemWrite_i(wr0),
    .addr_i(addr0), .data_i(wdata0), .data_o(rdata0), .done_o(done0),
    .stall_o(stall0)
`ifdef DMEM_ALIGN_CHECK_EN
    , .err_o(err0)
`endif
  );

`ifndef DMEM_ALIGN_CHECK_EN
  assign err  = 1'b0;
  assign err0 = 1'b0;
`endif

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] m_rdata = '0;

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the WAIT_CYCLES=2 instance; timing and data come from the model.
  task automatic access(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int unsigned n;
    int unsigned idx;
    bit          mis;
    wr = w; rd = r; addr = a; wdata = d;
    #1;
    chk({tag, " stall@accept"}, 32'(stall), 32'd1);
    n = 0;
    forever begin
      tick();
      n++;
      if (done === 1'b1 || n >= 40) break;
      chk({tag, " stall busy"}, 32'(stall), 32'd1);
      if (ALIGN) chk({tag, " err busy"}, 32'(err), 32'd0);
    end
    chk({tag, " latency"}, 32'(n), 32'(W + 1));
    chk({tag, " stall@done"}, 32'(stall), 32'd0);
    idx = (a >> 2) % DEPTH;
    mis = ALIGN && (a[1:0] != 2'b00);
    if (!mis) begin
      if (w) model[idx] = d;
      else   m_rdata    = model[idx];
    end
    chk({tag, " data_o"}, rdata, m_rdata);
    if (ALIGN) chk({tag, " err@done"}, 32'(err), 32'(mis));
    wr = 1'b0; rd = 1'b0;
    tick();
    chk({tag, " done drops"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{w: 1'b0, r: 1'b1, a: 32'h40,  d: 32'h0,        exp: 32'h0};
    tbl[1] = '{w: 1'b1, r: 1'b0, a: 32'h10,  d: 32'hDEADBEEF, exp: 32'h0};
    tbl[2] = '{w: 1'b0, r: 1'b1, a: 32'h10,  d: 32'h0,        exp: 32'hDEADBEEF};
    tbl[3] = '{w: 1'b1, r: 1'b1, a: 32'h204, d: 32'hAAAA0001, exp: 32'hDEADBEEF};
    tbl[4] = '{w: 1'b0, r: 1'b1, a: 32'h004, d: 32'h0,        exp: 32'hAAAA0001};
    tbl[5] = '{w: 1'b0, r: 1'b1, a: 32'h10,  d: 32'h0,        exp: 32'hDEADBEEF};
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    // Reset with a request pending: stall still follows req in IDLE.
    rd = 1'b1;
    tick();
    chk("reset stall with req", 32'(stall), 32'd1);
    rd = 1'b0;
    tick();
    chk("reset data_o", rdata, 32'h0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset data_o w0", rdata0, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle done", 32'(done), 32'd0);
    chk("idle stall", 32'(stall), 32'd0);

    for (int i = 0; i < 6; i++) begin
      access(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d expected", i), rdata, tbl[i].exp);
    end

    for (int i = 0; i < 60; i++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = ($urandom & 32'hFFFF_FE00) | ($urandom_range(0, 15) << 2) | ($urandom & 32'h3);
      access(op != 0, op != 1, a, $urandom, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) begin
        addr = $urandom; wdata = $urandom;
        tick();
        chk("gap stall", 32'(stall), 32'd0);
      end
    end

    // Reset during BUSY abandons the write and clears memory.
    wr = 1'b1; addr = 32'h20; wdata = 32'h55;
    tick();
    chk("midrst busy stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst idle stall", 32'(stall), 32'd1);
    wr = 1'b0;
    #1;
    chk("midrst stall released", 32'(stall), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst no done", 32'(done), 32'd0);
    end
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    m_rdata = '0;
    access(1'b0, 1'b1, 32'h20, 32'h0, "midrst read");
    chk("midrst read value", rdata, 32'h0);

    // Zero wait states: one stall cycle, then done.
    wr0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h12345678;
    #1;
    chk("w0 wr stall", 32'(stall0), 32'd1);
    chk("w0 wr no done", 32'(done0), 32'd0);
    tick();
    chk("w0 wr done", 32'(done0), 32'd1);
    chk("w0 wr stall@done", 32'(stall0), 32'd0);
    wr0 = 1'b0;
    tick();
    chk("w0 idle done", 32'(done0), 32'd0);
    rd0 = 1'b1;
    #1;
    chk("w0 rd stall", 32'(stall0), 32'd1);
    tick();
    chk("w0 rd done", 32'(done0), 32'd1);
    chk("w0 rd data", rdata0, 32'h12345678);
    rd0 = 1'b0;
    tick();

    if (ALIGN) begin
      access(1'b1, 1'b0, 32'h22, 32'h77, "align wr");
      access(1'b0, 1'b1, 32'h20, 32'h0, "align rd");
      chk("align rd value", rdata, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipelined CPU's MEM stage. It accepts the pipeline's MemRead/MemWrite requests, holds them for a programmable number of wait states, then commits the write or returns the read word. While a request is pending it drives a stall back to the pipeline, which freezes every pipeline register until the response cycle. It replaces the zero-latency data memory whenever slow-memory behaviour has to be exercised.

## Interface
Parameters:
- DEPTH, 128, number of 32-bit words; power of two, at least 2.
- WAIT_CYCLES, 2, wait states between acceptance and response; range 0..15.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- MemRead_i  in  1  read request, level.
- MemWrite_i  in  1  write request, level.
- addr_i  in  32  byte address.
- data_i  in  32  write data.
- data_o  out  32  read data, valid when done_o=1 for a read; held until the next read completes.
- done_o  out  1  one-cycle response strobe.
- stall_o  out  1  pipeline freeze request; combinational.
- err_o  out  1  misalignment flag; exists only with DMEM_ALIGN_CHECK_EN.

## Operation
- Storage: DEPTH x 32 array. Word index = addr_i[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH. addr_i[1:0] is ignored unless the alignment check is compiled in.
- Request present: req = MemRead_i | MemWrite_i. If both are high, the request is a write; data_o is unchanged.
- States:
  - IDLE: if req, latch op, index and data_i. Go to BUSY with cnt=WAIT_CYCLES, or straight to DONE if WAIT_CYCLES=0.
  - BUSY: cnt decrements each cycle. On the edge where cnt==1, go to DONE.
  - DONE: always returns to IDLE. req is ignored in this cycle, because it is the same request the pipeline is still presenting.
- The operation is committed on the edge that enters DONE:
  - Write: mem[index] <= latched data.
  - Read: data_o <= mem[index].
- stall_o = (IDLE & req) | BUSY. stall_o is 0 in DONE, so the pipeline advances on the DONE edge.
- Request inputs are only sampled in IDLE. Changes during BUSY are ignored.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE, cnt=0.
  - data_o=0, done_o=0, err_o=0.
  - Every memory word=0.
  - stall_o follows its combinational equation, so it is 1 if req is high during reset while the state is IDLE.
- Latency: a request accepted at edge k gets done_o=1 during cycle k+WAIT_CYCLES+1 (counting the cycle after edge k as k+1).
- Total stall per access is WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0 the stall is still 1 cycle.
- Back-to-back requests: after DONE there is at least one IDLE cycle, and a new request is accepted there. Minimum spacing between accepts is WAIT_CYCLES+2 cycles.
- Reset mid-operation: the pending access is abandoned with no commit, done_o is not raised, and the memory is cleared.
- Read of a word written by the immediately preceding request returns the new value.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A request with addr_i[1:0]!=0 is still accepted and timed normally.
  - In its DONE cycle err_o=1 together with done_o.
  - A misaligned write is suppressed (memory unchanged).
  - A misaligned read leaves data_o unchanged.
  - err_o is 0 in every other cycle.
- DMEM_ALIGN_CHECK_EN undefined:
  - The err_o port is absent.
  - addr_i[1:0] is ignored and misaligned accesses behave as aligned.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, then no requests. Required: data_o=0, done_o=0, stall_o=0. A read of addr 0x40 returns 0.
- Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 at edge k. Required: stall_o=1 for cycles k..k+2 and done_o=1 at cycle k+3. A following read of 0x10 returns 0xDEADBEEF with done_o three cycles after its accept.
- WAIT_CYCLES=0: write 0x12345678 to 0x8. Required: stall_o high for exactly 1 cycle, then done_o. A read of 0x8 returns 0x12345678.
- Wrap and conflict, DEPTH=128: write 0xAAAA0001 to 0x204 with MemRead_i=1 too. Required: treated as a write, data_o unchanged. A read of 0x004 returns 0xAAAA0001.
- Reset mid-BUSY: start a write of 0x55 to 0x20 and pull rst_n low during BUSY. Required: no done_o, state IDLE, and a read of 0x20 returns 0.
- DMEM_ALIGN_CHECK_EN: write 0x77 to 0x22. Required: err_o=1 and done_o=1 in the same cycle, and a read of 0x20 returns the prior value 0.
